// File: rtl/mbist_fail_collector.sv
// mbist_fail_collector: compares memory read data against the controller's expected data,
// counts and logs the first failing locations, and unloads the log through a scan chain.
module mbist_fail_collector #(
  parameter int BG_DATA   = 2,
  parameter int ADDR_X    = 2,
  parameter int ADDR_Y    = 2,
  parameter int RD_LAT    = 1,
  parameter int LOG_DEPTH = 4,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_mbist_run,
  input  logic [ADDR_X-1:0] i_addr_x,
  input  logic [ADDR_Y-1:0] i_addr_y,
  input  logic [BG_DATA-1:0] i_exp_data,
  input  logic              i_re,
  input  logic              i_comp_en,
  input  logic [BG_DATA-1:0] i_mem_q,
  input  logic              i_shift_en,
  input  logic              si,
  output logic              so,
  output logic              o_fail_flag,
  output logic [CNT_W-1:0]  o_fail_cnt
);
  localparam int ENTRY_W = ADDR_Y + ADDR_X + BG_DATA;
  localparam int CHAIN_W = LOG_DEPTH * ENTRY_W + CNT_W + 1;
  localparam int CNT_LSB = LOG_DEPTH * ENTRY_W;
  localparam int STG_W   = 1 + ENTRY_W;
  localparam int PTR_W   = $clog2(LOG_DEPTH + 1);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(LOG_DEPTH);

  logic [RD_LAT*STG_W-1:0] r_pipe;
  logic [CHAIN_W-1:0]      r_chain;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic                    r_sticky;
  logic                    r_run_q;
  logic [RD_LAT*STG_W-1:0] w_pipe_nxt;
  logic [STG_W-1:0]        w_stg_in;
  logic                    w_vld_d;
  logic [ADDR_Y-1:0]       w_y_d;
  logic [ADDR_X-1:0]       w_x_d;
  logic [BG_DATA-1:0]      w_exp_d;
  logic                    w_clr;
  logic                    w_mis;
  logic [CNT_W-1:0]        w_cnt;
  logic [CNT_LSB-1:0]      w_log;

  assign w_stg_in = {i_re & i_comp_en & ~i_shift_en, i_addr_y, i_addr_x, i_exp_data};
  // Newest stage sits in the LSBs; the oldest (RD_LAT cycles old) at the top.
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign w_pipe_nxt = w_stg_in;
    end else begin : g_latn
      assign w_pipe_nxt = {r_pipe[(RD_LAT-1)*STG_W-1:0], w_stg_in};
    end
  endgenerate
  assign {w_vld_d, w_y_d, w_x_d, w_exp_d} = r_pipe[(RD_LAT-1)*STG_W +: STG_W];

  assign w_clr       = i_mbist_run & ~r_run_q;
  assign w_mis       = w_vld_d & (i_mem_q !== w_exp_d);
  assign w_cnt       = r_chain[CNT_LSB +: CNT_W];
  assign so          = r_chain[0];
  assign o_fail_cnt  = w_cnt;
  assign o_fail_flag = r_sticky | (|w_cnt);

  generate
    for (genvar e = 0; e < LOG_DEPTH; e++) begin : g_ent
      assign w_log[e*ENTRY_W +: ENTRY_W] = (r_wr_ptr == PTR_W'(e)) ?
        {w_y_d, w_x_d, i_mem_q} : r_chain[e*ENTRY_W +: ENTRY_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pipe <= '0;
    else r_pipe <= w_pipe_nxt;
  end

  // Priority: clear on run rising edge, then shift, then mismatch logging.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chain  <= '0;
      r_wr_ptr <= '0;
      r_sticky <= 1'b0;
      r_run_q  <= 1'b0;
    end else begin
      r_run_q <= i_mbist_run;
      if (w_clr) begin
        r_chain  <= '0;
        r_wr_ptr <= '0;
        r_sticky <= 1'b0;
      end else if (i_shift_en) begin
        r_chain <= {si, r_chain[CHAIN_W-1:1]};
      end else if (w_mis) begin
        r_sticky <= 1'b1;
        r_chain[CNT_LSB +: CNT_W] <= (&w_cnt) ? w_cnt : w_cnt + 1'b1;
        if (r_wr_ptr < DEPTH_P) begin
          r_chain[CNT_LSB-1:0] <= w_log;
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end else begin
          r_chain[CHAIN_W-1] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mbist_fail_collector.sv
// tb_mbist_fail_collector: directed checks of compare, logging, saturation, clear and scan unload.
module tb_mbist_fail_collector;
  logic clk = 1'b0;
  logic reset, run, re, ce, sh, si;
  logic [1:0] ax, ay, ex, q, e_v, pe;
  logic so, flag, so2, flag2;
  logic [3:0] cnt, cnt2;
  int checks = 0;
  int errors = 0;
  logic [5:0] m_ent[4];
  int m_ptr, m_cnt;
  logic m_ovf, m_sticky;
  logic sb[$];

  always #5 clk = ~clk;

  mbist_fail_collector dut (
    .clk(clk), .reset(reset), .i_mbist_run(run), .i_addr_x(ax), .i_addr_y(ay),
    .i_exp_data(ex), .i_re(re), .i_comp_en(ce), .i_mem_q(q), .i_shift_en(sh),
    .si(si), .so(so), .o_fail_flag(flag), .o_fail_cnt(cnt)
  );

  mbist_fail_collector #(.RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .i_mbist_run(run), .i_addr_x(ax), .i_addr_y(ay),
    .i_exp_data(ex), .i_re(re), .i_comp_en(ce), .i_mem_q(q), .i_shift_en(sh),
    .si(si), .so(so2), .o_fail_flag(flag2), .o_fail_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [1:0] x, input logic [1:0] y,
                     input logic [1:0] e, input logic [1:0] d);
    re = r; ce = r; ax = x; ay = y; ex = e; q = d;
    @(posedge clk); #1;
  endtask

  task automatic mdl_clr();
    m_ptr = 0; m_cnt = 0; m_ovf = 1'b0; m_sticky = 1'b0;
    for (int i = 0; i < 4; i++) m_ent[i] = '0;
  endtask

  task automatic mis(input logic [1:0] x, input logic [1:0] y, input logic [1:0] d);
    m_sticky = 1'b1;
    if (m_cnt < 15) m_cnt++;
    if (m_ptr < 4) begin
      m_ent[m_ptr] = {y, x, d};
      m_ptr++;
    end else m_ovf = 1'b1;
  endtask

  task automatic do_reset();
    re = 0; ce = 0; sh = 0; run = 0;
    @(posedge clk); #2 reset = 1'b1;
    #2 reset = 1'b0;
    mdl_clr();
  endtask

  // Expected chain bits are queued from the model, then popped against so on each shift.
  task automatic scan(input string tag);
    logic [28:0] ev;
    ev = '0;
    for (int i = 0; i < 4; i++) ev[i*6 +: 6] = m_ent[i];
    ev[24 +: 4] = m_cnt[3:0];
    ev[28] = m_ovf;
    for (int k = 0; k < 29; k++) sb.push_back(ev[k]);
    re = 0; ce = 0; si = 0; sh = 1;
    for (int k = 0; k < 29; k++) begin
      chk(tag, so, sb.pop_front());
      @(posedge clk); #1;
    end
    sh = 0;
    m_cnt = 0; m_ovf = 1'b0;
    for (int i = 0; i < 4; i++) m_ent[i] = '0;
    chk({tag, "_flag_after"}, flag, m_sticky);
    chk({tag, "_cnt_after"}, cnt, 0);
  endtask

  initial begin
    reset = 1; run = 0; re = 0; ce = 0; sh = 0; si = 0;
    ax = 0; ay = 0; ex = 0; q = 0; pe = 0;
    mdl_clr();
    #3;
    chk("rst_flag", flag, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_so", so, 0);
    #9 reset = 0;

    for (int i = 0; i < 17; i++) begin
      e_v = 2'(i) ^ 2'(i >> 2);
      cyc(i < 16, 2'(i), 2'(i >> 2), e_v, pe);
      pe = e_v;
    end
    chk("pass_flag", flag, 0);
    chk("pass_cnt", cnt, 0);
    scan("pass_scan");

    cyc(1, 2'd2, 2'd1, 2'b01, 2'b00);
    cyc(0, 2'd0, 2'd0, 2'b00, 2'b11);
    mis(2'd2, 2'd1, 2'b11);
    chk("single_flag", flag, 1);
    chk("single_cnt", cnt, 1);
    scan("single_scan");

    do_reset();
    for (int i = 0; i < 7; i++) cyc(i < 6, 2'(i), 2'(i >> 2), 2'b00, (i > 0) ? 2'b10 : 2'b00);
    for (int i = 0; i < 6; i++) mis(2'(i), 2'(i >> 2), 2'b10);
    chk("six_cnt", cnt, 6);
    chk("six_flag", flag, 1);
    scan("six_scan");

    do_reset();
    for (int i = 0; i < 21; i++) cyc(i < 20, 2'(i), 2'(i >> 2), 2'b01, (i > 0) ? 2'b10 : 2'b01);
    for (int i = 0; i < 20; i++) mis(2'(i), 2'(i >> 2), 2'b10);
    chk("sat_cnt", cnt, 15);
    chk("sat_flag", flag, 1);

    cyc(1, 2'd3, 2'd3, 2'b00, 2'b00);
    run = 1;
    cyc(0, 2'd0, 2'd0, 2'b00, 2'b11);
    mdl_clr();
    chk("clr_flag", flag, 0);
    chk("clr_cnt", cnt, 0);
    scan("clr_scan");
    cyc(1, 2'd1, 2'd1, 2'b00, 2'b00);
    cyc(0, 2'd0, 2'd0, 2'b00, 2'b01);
    mis(2'd1, 2'd1, 2'b01);
    chk("post_clr_cnt", cnt, 1);
    scan("post_clr_scan");

    do_reset();
    cyc(1, 2'd0, 2'd0, 2'b00, 2'b00);
    cyc(0, 2'd0, 2'd0, 2'b00, 2'b11);
    cyc(0, 2'd0, 2'd0, 2'b00, 2'b00);
    chk("lat2_flag", flag2, 0);
    chk("lat2_cnt", cnt2, 0);
    chk("lat1_cnt", cnt, 1);
    cyc(1, 2'd1, 2'd0, 2'b10, 2'b00);
    cyc(0, 2'd0, 2'd0, 2'b00, 2'b10);
    cyc(0, 2'd0, 2'd0, 2'b00, 2'b01);
    chk("lat2_mis_cnt", cnt2, 1);
    chk("lat2_mis_flag", flag2, 1);

    sh = 1;
    chk("mid_so_pre", so, 1);
    @(posedge clk); #1;
    chk("mid_so_shift", so, 1);
    chk("mid_flag_pre", flag, 1);
    #2 reset = 1;
    #1;
    chk("mid_rst_so", so, 0);
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_flag", flag, 0);
    reset = 0; sh = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mbist_fail_collector.md
Name: mbist_fail_collector

Overview:
- Memory-side response checker for the pmbist controller.
- Receives the controller's address, expected data, read and compare-enable strobes, plus the memory's read data.
- Detects read mismatches, drives the fail flag back to the controller, counts fails and logs the first failing locations.
- The log is unloaded through the result scan path: the controller's si_to_mem drives this block's si; this block's so drives the controller's so_from_mem.

Parameters:
- BG_DATA, 2, data width.
- ADDR_X, 2, X address width.
- ADDR_Y, 2, Y address width.
- RD_LAT, 1, memory read latency in clk cycles (>=1).
- LOG_DEPTH, 4, number of fail entries logged.
- CNT_W, 4, fail counter width.
- Derived: ENTRY_W = ADDR_Y+ADDR_X+BG_DATA.
- Derived: CHAIN_W = LOG_DEPTH*ENTRY_W + CNT_W + 1.

Ports:
- clk  in  1  shared BIST clock (controller's muxed tck/f_clk).
- reset  in  1  asynchronous, active-high reset.
- i_mbist_run  in  1  controller run indication.
- i_addr_x  in  ADDR_X  controller X address.
- i_addr_y  in  ADDR_Y  controller Y address.
- i_exp_data  in  BG_DATA  controller background/expected data.
- i_re  in  1  read strobe.
- i_comp_en  in  1  compare enable.
- i_mem_q  in  BG_DATA  memory read data.
- i_shift_en  in  1  result shift enable (controller shift_result).
- si  in  1  scan in.
- so  out  1  scan out = chain bit 0.
- o_fail_flag  out  1  sticky fail, to controller i_fail_flags.
- o_fail_cnt  out  CNT_W  saturating fail count.

Behaviour:
- Reset: all registers clear to 0; o_fail_flag=0, o_fail_cnt=0, so=0, log empty, overflow=0, pipeline empty.
- Compare pipeline:
  - tap = i_re & i_comp_en & ~i_shift_en.
  - tap, i_addr_x, i_addr_y and i_exp_data are delayed exactly RD_LAT cycles.
  - In cycle T+RD_LAT, mismatch = valid_d & (i_mem_q != exp_d).
- On mismatch, all registered, visible in the next cycle:
  - o_fail_flag <= 1 (sticky).
  - o_fail_cnt increments, saturating at 2^CNT_W-1.
  - If wr_ptr < LOG_DEPTH: entry[wr_ptr] <= {addr_y_d, addr_x_d, i_mem_q} and wr_ptr increments.
  - If wr_ptr == LOG_DEPTH: the entry is not written and overflow <= 1.
- Back-to-back mismatches on consecutive cycles are all counted and logged; there are no gaps.
- Clear:
  - A rising edge of i_mbist_run (registered previous value 0, current 1) clears flag, counter, overflow, wr_ptr and all entries in that same clock.
  - Clear has priority over a mismatch in the same cycle; that mismatch is dropped.
  - The pipeline is not flushed; taps issued after the edge compare normally.
- Scan chain layout: entry i at chain[i*ENTRY_W +: ENTRY_W], then cnt at chain[LOG_DEPTH*ENTRY_W +: CNT_W], then overflow at the MSB.
  - Entry format is {addr_y, addr_x, q}; q is in the LSBs.
  - Unwritten entries read 0.
- Shift:
  - While i_shift_en=1, each clk does chain <= {si, chain[CHAIN_W-1:1]}; so = chain[0] (combinational from the register).
  - Shifting is destructive; after CHAIN_W shifts the chain holds the shifted-in bits.
  - o_fail_flag and o_fail_cnt follow the chain's flag/cnt fields. The flag is the OR of cnt != 0 and its own sticky bit; the sticky bit is cleared only by reset or clear.
  - Shift has priority over mismatch logging; compares are suppressed via the tap gating, and in-flight valid_d is ignored while shifting.
- wr_ptr is not scanned: after a shift, wr_ptr is unchanged, and new logging resumes at wr_ptr.
- Reset mid-run or mid-shift: immediate asynchronous return to all-zero state.
- X/Z on i_mem_q while valid_d=1 counts as mismatch (use !== in simulation; synthesis compares with !=).

Test Plan:
- Reset, then run 16 reads with i_mem_q == i_exp_data, RD_LAT=1 -> o_fail_flag=0, o_fail_cnt=0; 29 shifts out all zeros.
- Single mismatch: read at x=2, y=1, exp=2'b01, q=2'b11 one cycle later -> flag=1 in the next cycle, cnt=1; shifting gives bits[5:0]=6'b01_10_11, cnt field=1, overflow=0.
- Six consecutive mismatches at addresses 0..5 -> cnt=6; entries 0..3 hold addresses 0..3; overflow=1.
- 20 mismatches with CNT_W=4 -> cnt saturates at 15 with no wrap.
- Mismatch coincident with a rising edge of i_mbist_run -> all fields 0 afterward; flag=0.
- RD_LAT=2, with i_mem_q mismatching one cycle after the strobe and matching two cycles after -> no fail. Also: assert reset during a shift -> so=0 and cnt=0 immediately.
